// File: rtl/video_tpg_stream.sv
// video_tpg_stream: AXI4-Stream video test pattern generator with frame
// counting, inter-frame blanking and backpressure statistics.
module video_tpg_stream #(
    parameter int DW = 16,
    parameter int HW = 12,
    parameter int BW = 24
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic            enable_i,
    input  logic [1:0]      mode_i,
    input  logic [HW-1:0]   width_i,
    input  logic [HW-1:0]   height_i,
    input  logic [BW-1:0]   blank_i,
    input  logic [7:0]      frames_i,
    input  logic [DW-1:0]   const_i,
    output logic [DW-1:0]   TDATA,
    output logic            TVALID,
    input  logic            TREADY,
    output logic            TUSER,
    output logic            TLAST,
    output logic [DW/8-1:0] TKEEP,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [15:0]     frame_cnt_o,
    output logic [31:0]     stall_cnt_o
);
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK, DONE} state_t;
    state_t state, state_nxt;
    logic [HW-1:0] x, y, w_q, h_q;
    logic [1:0]    mode_q;
    logic [BW-1:0] blank_q, bcnt;
    logic [DW-1:0] const_q, pat;
    logic [7:0]    sent;
    logic          latch, clr, cfg_ok, xfer, eol, eof;

    assign cfg_ok = width_i != '0 && height_i != '0;
    assign TVALID = state == ACTIVE;
    assign xfer   = TVALID && TREADY;
    assign eol    = x == w_q - HW'(1);
    assign eof    = eol && y == h_q - HW'(1);
    assign busy_o = state == ACTIVE || state == BLANK;
    assign done_o = state == DONE;

    always_comb
        pat = mode_q == 2'd0 ? DW'(x) + DW'(y) :
              mode_q == 2'd1 ? {DW{x[4] ^ y[4]}} :
              mode_q == 2'd2 ? const_q : {(DW/8){frame_cnt_o[7:0]}};

    // Outputs are gated by TVALID so reset clears them without extra registers.
    assign TDATA = TVALID ? pat : '0;
    assign TUSER = TVALID && x == '0 && y == '0;
    assign TLAST = TVALID && eol;
    assign TKEEP = {(DW/8){TVALID}};

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE:
                if (enable_i && cfg_ok) begin
                    state_nxt = ACTIVE;
                    latch     = 1'b1;
                    clr       = 1'b1;
                end
            ACTIVE:
                if (xfer && eof) begin
                    if (frames_i != 8'd0 && sent + 8'd1 == frames_i) state_nxt = DONE;
                    else if (!enable_i) state_nxt = IDLE;
                    else if (blank_q != '0) state_nxt = BLANK;
                    else if (cfg_ok) latch = 1'b1;
                    else state_nxt = IDLE;
                end
            BLANK:
                if (bcnt == '0) begin
                    state_nxt = cfg_ok ? ACTIVE : IDLE;
                    latch     = cfg_ok;
                end
            DONE:
                if (!enable_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            w_q         <= '0;
            h_q         <= '0;
            mode_q      <= '0;
            blank_q     <= '0;
            const_q     <= '0;
            bcnt        <= '0;
            sent        <= '0;
            frame_cnt_o <= '0;
            stall_cnt_o <= '0;
            err_o       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                w_q     <= width_i;
                h_q     <= height_i;
                mode_q  <= mode_i;
                blank_q <= blank_i;
                const_q <= const_i;
                x       <= '0;
                y       <= '0;
            end else if (xfer) begin
                x <= eol ? '0 : x + HW'(1);
                y <= eof ? '0 : eol ? y + HW'(1) : y;
            end
            if (state == ACTIVE && state_nxt == BLANK)
                bcnt <= blank_q - BW'(1);
            else if (state == BLANK)
                bcnt <= bcnt - BW'(1);
            sent <= clr ? 8'd0 : (xfer && eof) ? sent + 8'd1 : sent;
            if (xfer && eof)
                frame_cnt_o <= frame_cnt_o + 16'd1;
            if (clr)
                stall_cnt_o <= '0;
            else if (TVALID && !TREADY && ~&stall_cnt_o)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (state == IDLE)
                err_o <= enable_i && !cfg_ok;
        end
    end
endmodule

// File: tb/tb_video_tpg_stream.sv
// tb_video_tpg_stream: directed checks of the test pattern generator covering
// patterns, handshake stalls, blanking, graceful stop, bad config and reset.
module tb_video_tpg_stream;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] width, height;
    logic [23:0] blank;
    logic [7:0]  frames;
    logic [15:0] cval;
    logic [15:0] tdata;
    logic        tvalid, tready, tuser, tlast;
    logic [1:0]  tkeep;
    logic        busy, done, err;
    logic [15:0] frame_cnt;
    logic [31:0] stall_cnt;
    logic [15:0] exp_fc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          gap;

    always #5 clk = ~clk;

    video_tpg_stream #(.DW(16), .HW(12), .BW(24)) dut (
        .ACLK(clk), .ARESETn(rst_n), .enable_i(enable), .mode_i(mode),
        .width_i(width), .height_i(height), .blank_i(blank), .frames_i(frames),
        .const_i(cval), .TDATA(tdata), .TVALID(tvalid), .TREADY(tready),
        .TUSER(tuser), .TLAST(tlast), .TKEEP(tkeep), .busy_o(busy),
        .done_o(done), .err_o(err), .frame_cnt_o(frame_cnt), .stall_cnt_o(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] px(input int x, input int y, input int m, input logic [15:0] cv);
        case (m)
            0: px = 16'(x + y);
            1: px = (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            2: px = cv;
            default: px = {exp_fc[7:0], exp_fc[7:0]};
        endcase
    endfunction

    // Expects the first beat of a frame to be on the bus; ends after the last transfer.
    task automatic run_frame(input int w, input int h, input int m, input logic [15:0] cv, input int drop);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                if (yy == drop && xx == 0) enable = 1'b0;
                chk("valid", 32'(tvalid), 32'd1);
                chk("data", 32'(tdata), 32'(px(xx, yy, m, cv)));
                chk("user", 32'(tuser), 32'(xx == 0 && yy == 0));
                chk("last", 32'(tlast), 32'(xx == w - 1));
                chk("keep", 32'(tkeep), 32'd3);
                tick();
            end
        exp_fc++;
    endtask

    task automatic wait_valid(output int g);
        g = 0;
        while (!tvalid && g < 100) begin
            g++;
            tick();
        end
        if (g >= 100) chk("valid_timeout", 32'(tvalid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; width = 12'd4; height = 12'd2;
        blank = 24'd0; frames = 8'd1; cval = 16'h0; tready = 1'b1; exp_fc = 16'd0;
        repeat (2) tick();
        chk("rst_valid", 32'(tvalid), 32'd0);
        chk("rst_data", 32'(tdata), 32'd0);
        chk("rst_keep", 32'(tkeep), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        // basic 4x2 frame, mode 0
        enable = 1'b1;
        tick();
        chk("busy_active", 32'(busy), 32'd1);
        run_frame(4, 2, 0, 16'h0, -1);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_valid", 32'(tvalid), 32'd0);
        chk("basic_busy", 32'(busy), 32'd0);
        chk("basic_fcnt", 32'(frame_cnt), 32'd1);
        enable = 1'b0;
        tick();
        chk("done_clear", 32'(done), 32'd0);
        // backpressure: three stalled cycles on beat 2
        enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("bp_data", 32'(tdata), 32'(px(i % 4, i / 4, 0, 16'h0)));
            if (i == 2) begin
                tready = 1'b0;
                repeat (3) begin
                    tick();
                    chk("bp_hold_data", 32'(tdata), 32'd2);
                    chk("bp_hold_valid", 32'(tvalid), 32'd1);
                end
                tready = 1'b1;
            end
            tick();
        end
        exp_fc++;
        chk("bp_stall", stall_cnt, 32'd3);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_fcnt", 32'(frame_cnt), 32'(exp_fc));
        enable = 1'b0;
        tick();
        // blanking of 3 cycles; mode changed mid-frame only applies to frame 2
        mode = 2'd2; cval = 16'hABCD; blank = 24'd3; frames = 8'd2;
        enable = 1'b1;
        tick();
        mode = 2'd3; cval = 16'h1234;
        run_frame(4, 2, 2, 16'hABCD, -1);
        chk("blank_busy", 32'(busy), 32'd1);
        wait_valid(gap);
        chk("blank_gap", 32'(gap), 32'd3);
        run_frame(4, 2, 3, 16'h0, -1);
        chk("blank_done", 32'(done), 32'd1);
        chk("blank_fcnt", 32'(frame_cnt), 32'(exp_fc));
        enable = 1'b0;
        tick();
        // gap-free back-to-back frames, checkerboard pattern
        mode = 2'd1; width = 12'd40; height = 12'd20; blank = 24'd0; frames = 8'd2;
        enable = 1'b1;
        tick();
        run_frame(40, 20, 1, 16'h0, -1);
        wait_valid(gap);
        chk("nogap", 32'(gap), 32'd0);
        run_frame(40, 20, 1, 16'h0, -1);
        chk("nogap_done", 32'(done), 32'd1);
        enable = 1'b0;
        tick();
        // graceful stop: continuous mode, enable dropped at line 3
        mode = 2'd0; width = 12'd8; height = 12'd6; blank = 24'd2; frames = 8'd0;
        enable = 1'b1;
        tick();
        run_frame(8, 6, 0, 16'h0, 3);
        chk("stop_valid", 32'(tvalid), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_fcnt", 32'(frame_cnt), 32'(exp_fc));
        repeat (3) tick();
        chk("stop_idle", 32'(tvalid), 32'd0);
        // invalid configuration
        width = 12'd0;
        enable = 1'b1;
        tick();
        chk("err_set", 32'(err), 32'd1);
        tick();
        chk("err_valid", 32'(tvalid), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        tick();
        chk("err_clear", 32'(err), 32'd0);
        // reset mid-frame
        width = 12'd4; height = 12'd2; blank = 24'd0; frames = 8'd0;
        enable = 1'b1;
        tick();
        repeat (3) tick();
        chk("pre_rst_data", 32'(tdata), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(tvalid), 32'd0);
        chk("arst_data", 32'(tdata), 32'd0);
        chk("arst_last", 32'(tlast), 32'd0);
        chk("arst_keep", 32'(tkeep), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_fcnt", 32'(frame_cnt), 32'd0);
        chk("arst_stall", stall_cnt, 32'd0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(tvalid), 32'd0);
        exp_fc = 16'd0;
        enable = 1'b1;
        tick();
        run_frame(4, 2, 0, 16'h0, 0);
        chk("post_rst_fcnt", 32'(frame_cnt), 32'd1);
        chk("post_rst_idle2", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
